// File: rtl/acc_requant_drain_pkg.sv
// Shared constants, types and helpers for the accumulator drain.
// Holds array geometry, INT8 limits, FSM state and FIFO beat layout.
package acc_requant_drain_pkg;

    localparam int ARRAY_COL   = 16;
    localparam int ACC_WIDTH   = 32;
    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int MULT_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 5;
    localparam int INT8_MAX    = 127;
    localparam int INT8_MIN    = -128;

    localparam int VEC_WIDTH   = ARRAY_COL * DATA_WIDTH;
    localparam int PROD_WIDTH  = ACC_WIDTH + MULT_WIDTH + 1;
    localparam int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1;

    localparam logic signed [PROD_WIDTH-1:0] P_MAX = PROD_WIDTH'(INT8_MAX);
    localparam logic signed [PROD_WIDTH-1:0] P_MIN = PROD_WIDTH'(INT8_MIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FLUSH,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic                 last;
        logic [VEC_WIDTH-1:0] data;
    } beat_t;

    function automatic logic [DATA_WIDTH-1:0] sat_int8(
        input logic signed [PROD_WIDTH-1:0] v
    );
        if (v > P_MAX) begin
            return DATA_WIDTH'(INT8_MAX);
        end
        if (v < P_MIN) begin
            return DATA_WIDTH'(INT8_MIN);
        end
        return v[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/acc_requant_drain_fifo.sv
// requant_out_fifo: synchronous FIFO for {last, data} output beats.
// Ports: push/push_data, pop/pop_data (head, combinational), empty, count.
module requant_out_fifo
    import acc_requant_drain_pkg::*;
#(
    parameter  int WIDTH = VEC_WIDTH + 1,
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (cnt != CNT_W'(DEPTH));
    assign do_pop   = pop && (cnt != '0);
    assign pop_data = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/acc_requant_drain.sv
// Drains the accumulator bank, requantizes each lane to INT8 and streams
// packed vectors out. Ports: start/cfg_*, acc_rd_*, out_* handshake, busy, done.
module acc_requant_drain
    import acc_requant_drain_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            cfg_num_rows,
    input  logic [MULT_WIDTH-1:0]          cfg_mult,
    input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
    input  logic [DATA_WIDTH-1:0]          cfg_zero_point,
    input  logic                           cfg_relu_en,
    output logic                           acc_rd_en,
    output logic [ADDR_WIDTH-1:0]          acc_rd_addr,
    input  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [VEC_WIDTH-1:0]           out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam logic [ADDR_WIDTH:0] ROW_ONE = (ADDR_WIDTH+1)'(1);

    state_e state;
    state_e state_nxt;

    logic [ADDR_WIDTH:0]     rows_q;
    logic [MULT_WIDTH-1:0]   mult_q;
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic [DATA_WIDTH-1:0]   zp_q;
    logic                    relu_q;

    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [CNT_WIDTH-1:0]    inflight_q;
    logic [CNT_WIDTH-1:0]    fifo_count;
    logic                    fifo_empty;
    logic                    credit_ok;
    logic                    is_last_rd;
    logic                    start_take;
    logic                    pop;
    logic                    drained;

    logic                    s0_v;
    logic                    s0_last;
    logic                    s1_v;
    logic                    s1_last;
    logic                    s2_v;
    logic                    s2_last;
    logic [VEC_WIDTH-1:0]    s2_d;
    logic [VEC_WIDTH-1:0]    s2_data;

    beat_t                   push_beat;
    beat_t                   head;

    // Reads in flight plus buffered beats may never exceed the FIFO depth.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight_q})
                        < (CNT_WIDTH+1)'(FIFO_DEPTH);
    assign is_last_rd = ({1'b0, rd_addr_q} == (rows_q - ROW_ONE));
    assign start_take = start && (state == ST_IDLE);
    assign pop        = out_valid && out_ready;
    assign drained    = (inflight_q == '0)
                        && (fifo_empty
                            || ((fifo_count == CNT_WIDTH'(1)) && pop));

    assign busy        = (state != ST_IDLE);
    assign acc_rd_addr = rd_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_rd_en = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (cfg_num_rows == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    acc_rd_en = 1'b1;
                    if (is_last_rd) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (drained) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q  <= '0;
            mult_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            relu_q  <= 1'b0;
        end else if (start_take) begin
            rows_q  <= cfg_num_rows;
            mult_q  <= cfg_mult;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zero_point;
            relu_q  <= cfg_relu_en;
        end
    end

    // Address parks on the final row so it never passes rows-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
        end else if (start_take) begin
            rd_addr_q <= '0;
        end else if (acc_rd_en && !is_last_rd) begin
            rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        end
    end

    // Reads leave the in-flight count when their result enters the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            unique case ({acc_rd_en, s2_v})
                2'b10:   inflight_q <= inflight_q + CNT_WIDTH'(1);
                2'b01:   inflight_q <= inflight_q - CNT_WIDTH'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v    <= 1'b0;
            s0_last <= 1'b0;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s0_v    <= acc_rd_en;
            s0_last <= acc_rd_en && is_last_rd;
            s1_v    <= s0_v;
            s1_last <= s0_last;
            s2_v    <= s1_v;
            s2_last <= s1_last;
        end
    end

    for (genvar l = 0; l < ARRAY_COL; l++) begin : g_lane
        logic signed [ACC_WIDTH-1:0]  acc;
        logic signed [PROD_WIDTH-1:0] prod;
        logic signed [PROD_WIDTH-1:0] prod_q;
        logic signed [PROD_WIDTH-1:0] rnd;
        logic signed [PROD_WIDTH-1:0] shifted;
        logic signed [PROD_WIDTH-1:0] clamped;
        logic signed [PROD_WIDTH-1:0] biased;

        assign acc  = acc_rd_data[l*ACC_WIDTH +: ACC_WIDTH];
        assign prod = PROD_WIDTH'(acc)
                      * PROD_WIDTH'($signed({1'b0, mult_q}));

        always_ff @(posedge clk) begin
            if (s0_v) begin
                prod_q <= prod;
            end
        end

        // Round half up: add half an LSB of the result before shifting.
        always_comb begin
            rnd = '0;
            if (shift_q != '0) begin
                rnd = PROD_WIDTH'(1) << (shift_q - SHIFT_WIDTH'(1));
            end
            shifted = (prod_q + rnd) >>> shift_q;
            clamped = (relu_q && shifted[PROD_WIDTH-1]) ? '0 : shifted;
            biased  = clamped + PROD_WIDTH'($signed(zp_q));
        end

        assign s2_d[l*DATA_WIDTH +: DATA_WIDTH] = sat_int8(biased);
    end

    always_ff @(posedge clk) begin
        if (s1_v) begin
            s2_data <= s2_d;
        end
    end

    assign push_beat = '{last: s2_last, data: s2_data};

    requant_out_fifo #(
        .WIDTH (VEC_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_v),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head.data : '0;
    assign out_last  = out_valid && head.last;

endmodule

// File: doc/acc_requant_drain.md
Name: acc_requant_drain

Overview:
- Downstream stage of the accelerator core. Drains the accumulator bank after a tile completes.
- Reads one ARRAY_COL-wide vector of signed ACC_WIDTH partial sums per bank address.
- Requantizes every lane to INT8 using a fixed-point multiplier, a rounding right-shift, a zero point and optional ReLU.
- Streams the packed INT8 vectors out on a valid/ready interface toward the output buffer or DMA.

Parameters:
- ARRAY_COL, 16, lanes per vector; equals the systolic array column count.
- ACC_WIDTH, 32, signed accumulator lane width.
- DATA_WIDTH, 8, signed output lane width.
- ADDR_WIDTH, 4, accumulator bank address width (depth 16).
- FIFO_DEPTH, 4, output buffer depth; power of two, at least 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a drain
- cfg_num_rows  in  ADDR_WIDTH+1  vectors to drain, 0..16
- cfg_mult  in  16  unsigned requant multiplier
- cfg_shift  in  5  right-shift amount, 0..31
- cfg_zero_point  in  8  signed output zero point
- cfg_relu_en  in  1  clamp negative pre-zero-point results to 0
- acc_rd_en  out  1  bank read strobe
- acc_rd_addr  out  ADDR_WIDTH  bank read address
- acc_rd_data  in  ARRAY_COL*ACC_WIDTH  bank data; valid exactly 1 cycle after acc_rd_en
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accept
- out_data  out  ARRAY_COL*DATA_WIDTH  packed INT8 vector; lane i at bits [i*8 +: 8]
- out_last  out  1  marks the final vector of the drain
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last beat handshake

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, credit counter 0.
- FSM states and transitions:
  - IDLE: a start pulse latches all cfg_* inputs.
    - If cfg_num_rows == 0, go to DONE (no reads, no beats).
    - Otherwise go to ISSUE.
  - ISSUE: assert acc_rd_en with acc_rd_addr = 0,1,… in order, one read per cycle.
    - A read issues only when (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
    - After cfg_num_rows reads, go to FLUSH.
  - FLUSH: wait until the pipeline is empty and the last beat has been accepted, then go to DONE.
  - DONE: assert done for 1 cycle, then go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored; latched config does not change mid-drain.
- Pipeline from acc_rd_en to FIFO write:
  - Stage 0: bank read, 1 cycle.
  - Stage 1: per lane, p = signed(acc) * {0,cfg_mult}, 49-bit signed.
  - Stage 2: per lane, in order:
    - If shift > 0, r = (p + 2^(shift-1)) >>> shift (arithmetic shift, round half up); otherwise r = p.
    - If relu_en and r < 0, r = 0.
    - r = r + sign-extended zero_point.
    - Saturate to [-128, 127].
  - Latency: 3 cycles from acc_rd_en to FIFO write. With the FIFO empty and out_ready high, first out_valid is 4 cycles after the first acc_rd_en.
- Output FIFO: carries {last, data}. The last flag is tagged on the read whose address = cfg_num_rows-1.
- out_valid = FIFO not empty.
- out_data and out_last hold stable while out_valid && !out_ready.
- Credit scheme guarantees the FIFO never overflows; no data loss under any out_ready pattern.
- Address wrap: cfg_num_rows = 16 reads addresses 0..15. The address counter never exceeds cfg_num_rows-1.
- Simultaneous FIFO push and pop: allowed; occupancy unchanged.
- Reset mid-drain: immediate return to IDLE, FIFO flushed, out_valid = 0, no done pulse.

Decomposition:
- Shared params header holds ARRAY_COL, ACC_WIDTH, DATA_WIDTH, ADDR_WIDTH, plus INT8_MAX = 127 and INT8_MIN = -128.
- One natural sub-module: requant_out_fifo, a synchronous FIFO of width ARRAY_COL*DATA_WIDTH+1 and depth FIFO_DEPTH, with occupancy output.
- Per-lane requant arithmetic is a generate loop in the top level.

Test Plan:
- Identity pass-through: rows=1, mult=1, shift=0, zp=0, lanes {5,-3,0,…} → one beat {5,-3,0,…} with out_last=1; done one cycle after the handshake.
- Rounding: mult=1, shift=1; acc 3 → 2, acc -3 → -1, acc 1 → 1.
- Larger shift: mult=3, shift=2; acc 10 → 8 (30+2=32, >>2).
- Saturation and ReLU: mult=1, shift=0, zp=0; acc 1000 → 127, acc -1000 → -128. With relu_en=1, zp=10: acc -5 → 10.
- Backpressure: rows=16, out_ready alternates 1/0, then is held low 20 cycles.
  - 16 beats arrive in address order 0..15; out_last only on the 16th.
  - At most 4 reads are outstanding plus FIFO occupancy at any time.
  - out_data is stable while stalled.
- Control corners:
  - rows=0 → done with no acc_rd_en and no beats.
  - start pulsed while busy → ignored.
  - rst_n asserted after 5 beats → out_valid=0, busy=0 at once; a fresh start drains correctly from address 0.
